// File: rtl/lc3_io_controller.sv
// LC-3 memory-mapped I/O controller: keyboard FIFO plus display handshake.
// It decodes KBSR, KBDR, DSR and DDR on the MAR/MDR path. Read data is
// combinational; every register updates on the rising edge of clk.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   MAROut, MDROut        - address and write data from the core
//   memWE, ioRead         - core write and read strobes
//   ioSel, ioDataOut      - I/O page hit and read data, both combinational
//   kbData/kbValid/kbReady     - keyboard character input
//   dispData/dispValid/dispReady - display character output
//   intReq                - keyboard interrupt request
module lc3_io_controller #(
    parameter int unsigned KB_DEPTH  = 4,
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] MAROut,
    input  logic [15:0] MDROut,
    input  logic        memWE,
    input  logic        ioRead,
    output logic        ioSel,
    output logic [15:0] ioDataOut,
    input  logic [7:0]  kbData,
    input  logic        kbValid,
    output logic        kbReady,
    output logic [7:0]  dispData,
    output logic        dispValid,
    input  logic        dispReady,
    output logic        intReq
);

    localparam int unsigned PTR_W = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       kbMem [KB_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] kbCount;
    logic             kbIe;
    logic [7:0]       kbdrHold;
    logic [7:0]       dispBuf;
    logic             overrun;

    logic hitKbsr, hitKbdr, hitDsr, hitDdr;
    logic kbEmpty, kbPush, kbPop;
    logic wrKbsr, wrDsr, wrDdr, dispXfer;

    // Address decode
    assign hitKbsr = (MAROut == KBSR_ADDR);
    assign hitKbdr = (MAROut == KBDR_ADDR);
    assign hitDsr  = (MAROut == DSR_ADDR);
    assign hitDdr  = (MAROut == DDR_ADDR);
    assign ioSel   = hitKbsr | hitKbdr | hitDsr | hitDdr;

    // kbReady comes from the registered count, so a pop in a full cycle
    // cannot open a slot for a push in that same cycle.
    assign kbEmpty  = (kbCount == '0);
    assign kbReady  = (kbCount != CNT_W'(KB_DEPTH));
    assign kbPush   = kbValid & kbReady;
    assign kbPop    = ioRead & hitKbdr & ~kbEmpty;

    assign wrKbsr   = memWE & hitKbsr;
    assign wrDsr    = memWE & hitDsr;
    assign wrDdr    = memWE & hitDdr;
    assign dispXfer = dispValid & dispReady;

    assign intReq   = kbIe & ~kbEmpty;
    assign dispData = dispBuf;

    // Read data mux; zero outside the I/O page
    always_comb begin
        ioDataOut = 16'h0000;
        if (hitKbsr) begin
            ioDataOut = {~kbEmpty, kbIe, 14'b0};
        end else if (hitKbdr) begin
            ioDataOut = kbEmpty ? {8'h00, kbdrHold} : {8'h00, kbMem[rdPtr]};
        end else if (hitDsr) begin
            ioDataOut = {~dispValid, 14'b0, overrun};
        end else if (hitDdr) begin
            ioDataOut = {8'h00, dispBuf};
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (kbPush) begin
            kbMem[wrPtr] <= kbData;
        end
    end

    // Keyboard FIFO pointers, count, interrupt enable and hold register
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            kbCount  <= '0;
            kbIe     <= 1'b0;
            kbdrHold <= 8'h00;
        end else begin
            if (kbPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (kbPop) begin
                rdPtr    <= rdPtr + 1'b1;
                kbdrHold <= kbMem[rdPtr];
            end
            case ({kbPush, kbPop})
                2'b10:   kbCount <= kbCount + CNT_W'(1);
                2'b01:   kbCount <= kbCount - CNT_W'(1);
                default: kbCount <= kbCount;
            endcase
            if (wrKbsr) begin
                kbIe <= MDROut[14];
            end
        end
    end

    // Display buffer, handshake and sticky overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            dispBuf   <= 8'h00;
            dispValid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A store while a character is still pending is dropped and flagged,
            // even if that character completes its transfer on this edge.
            if (wrDdr && dispValid) begin
                overrun <= 1'b1;
            end else if (wrDsr && MDROut[0]) begin
                overrun <= 1'b0;
            end
            if (wrDdr && !dispValid) begin
                dispBuf   <= MDROut[7:0];
                dispValid <= 1'b1;
            end else if (dispXfer) begin
                dispValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lc3_io_controller.sv
// Self-checking bench for lc3_io_controller: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_lc3_io_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] MAROut = '0;
    logic [15:0] MDROut = '0;
    logic        memWE = 1'b0;
    logic        ioRead = 1'b0;
    logic        ioSel;
    logic [15:0] ioDataOut;
    logic [7:0]  kbData = '0;
    logic        kbValid = 1'b0;
    logic        kbReady;
    logic [7:0]  dispData;
    logic        dispValid;
    logic        dispReady = 1'b0;
    logic        intReq;

    lc3_io_controller dut (
        .clk       (clk),
        .reset     (reset),
        .MAROut    (MAROut),
        .MDROut    (MDROut),
        .memWE     (memWE),
        .ioRead    (ioRead),
        .ioSel     (ioSel),
        .ioDataOut (ioDataOut),
        .kbData    (kbData),
        .kbValid   (kbValid),
        .kbReady   (kbReady),
        .dispData  (dispData),
        .dispValid (dispValid),
        .dispReady (dispReady),
        .intReq    (intReq)
    );

    always #5 clk = ~clk;

    // Reference model state
    byte unsigned kbQ[$];
    bit          mIe, mDv, mOvr, modelValid;
    logic [7:0]  mHold, mBuf;
    logic        drdyCur;
    int          nVec, nErr;

    function automatic logic isIo(logic [15:0] a);
        return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
    endfunction

    function automatic logic [15:0] refRead(logic [15:0] a);
        logic [15:0] v;
        v = 16'h0000;
        if (a == 16'hFE00) begin
            if (kbQ.size() != 0) v = v + 16'h8000;
            if (mIe) v = v + 16'h4000;
        end else if (a == 16'hFE02) begin
            v = (kbQ.size() != 0) ? {8'h00, kbQ[0]} : {8'h00, mHold};
        end else if (a == 16'hFE04) begin
            v = mDv ? 16'h0000 : 16'h8000;
            if (mOvr) v = v + 16'h0001;
        end else if (a == 16'hFE06) begin
            v = {8'h00, mBuf};
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nVec++;
        assert (obs === exp)
        else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs, advance the model.
    task automatic drive(input logic rst, input logic [15:0] addr, input logic [15:0] mdr,
                         input logic we, input logic rd, input logic [7:0] kd,
                         input logic kv, input logic dr, input bit chk,
                         input logic [15:0] expv, input string tag);
        bit canPush, oldDv;
        reset = rst; MAROut = addr; MDROut = mdr; memWE = we; ioRead = rd;
        kbData = kd; kbValid = kv; dispReady = dr;
        #1;
        if (modelValid) begin
            check("ioSel",     16'(ioSel),     16'(isIo(addr)));
            check("ioDataOut", ioDataOut,      refRead(addr));
            check("kbReady",   16'(kbReady),   16'(kbQ.size() < 4));
            check("intReq",    16'(intReq),    16'(mIe && kbQ.size() != 0));
            check("dispValid", 16'(dispValid), 16'(mDv));
            check("dispData",  16'(dispData),  16'(mBuf));
        end
        if (chk) check(tag, ioDataOut, expv);
        if (rst) begin
            kbQ.delete();
            mIe = 0; mDv = 0; mOvr = 0; mHold = 8'h00; mBuf = 8'h00;
            modelValid = 1;
        end else begin
            canPush = (kbQ.size() < 4);
            oldDv   = mDv;
            if (rd && addr == 16'hFE02 && kbQ.size() != 0) mHold = kbQ.pop_front();
            if (kv && canPush) kbQ.push_back(kd);
            if (we && addr == 16'hFE00) mIe = mdr[14];
            if (we && addr == 16'hFE04 && mdr[0]) mOvr = 0;
            if (we && addr == 16'hFE06) begin
                if (oldDv) mOvr = 1;
                else begin mBuf = mdr[7:0]; mDv = 1; end
            end
            if (oldDv && dr) mDv = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic peek(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        drive(0, addr, 16'h0000, 0, 0, 8'h00, 0, drdyCur, 1, exp, tag);
    endtask

    task automatic push(input logic [7:0] c);
        drive(0, 16'h3000, 16'h0000, 0, 0, c, 1, drdyCur, 0, 16'h0000, "");
    endtask

    task automatic rdKb(input logic [15:0] exp, input string tag);
        drive(0, 16'hFE02, 16'h0000, 0, 1, 8'h00, 0, drdyCur, 1, exp, tag);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        drive(0, addr, data, 1, 0, 8'h00, 0, drdyCur, 0, 16'h0000, "");
    endtask

    task automatic doReset();
        drive(1, 16'h0000, 16'h0000, 0, 0, 8'h00, 0, drdyCur, 0, 16'h0000, "");
    endtask

    initial begin
        logic [15:0] ra;
        nVec = 0; nErr = 0; modelValid = 0; drdyCur = 0;
        mIe = 0; mDv = 0; mOvr = 0; mHold = 8'h00; mBuf = 8'h00;
        @(negedge clk);

        // Reset state and register reads
        doReset();
        peek(16'hFE00, 16'h0000, "rst_kbsr");
        peek(16'hFE02, 16'h0000, "rst_kbdr");
        peek(16'hFE04, 16'h8000, "rst_dsr");
        peek(16'hFE06, 16'h0000, "rst_ddr");
        peek(16'h1234, 16'h0000, "non_io");

        // FIFO order and hold-on-empty
        push(8'h41);
        push(8'h42);
        peek(16'hFE00, 16'h8000, "kbsr_2");
        rdKb(16'h0041, "kbdr_A");
        peek(16'hFE00, 16'h8000, "kbsr_1");
        rdKb(16'h0042, "kbdr_B");
        peek(16'hFE00, 16'h0000, "kbsr_0");
        rdKb(16'h0042, "kbdr_hold");

        // Full FIFO, refused push, pop-with-push while full
        push(8'h31); push(8'h32); push(8'h33); push(8'h34);
        check("kbReady_full", 16'(kbReady), 16'h0000);
        push(8'h35);
        drive(0, 16'hFE02, 16'h0000, 0, 1, 8'h36, 1, drdyCur, 1, 16'h0031, "kbdr_full_pop");
        rdKb(16'h0032, "kbdr_2");
        rdKb(16'h0033, "kbdr_3");
        rdKb(16'h0034, "kbdr_4");
        peek(16'hFE00, 16'h0000, "kbsr_drained");

        // Interrupt enable
        wr(16'hFE00, 16'h4000);
        check("intReq_empty", 16'(intReq), 16'h0000);
        push(8'h0D);
        check("intReq_set", 16'(intReq), 16'h0001);
        peek(16'hFE00, 16'hC000, "kbsr_ie");
        rdKb(16'h000D, "kbdr_cr");
        wr(16'hFE00, 16'h0000);

        // Display write, overrun, handshake, overrun clear
        drdyCur = 0;
        wr(16'hFE06, 16'h0048);
        wr(16'hFE06, 16'h0049);
        peek(16'hFE04, 16'h0001, "dsr_ovr");
        peek(16'hFE06, 16'h0048, "ddr_kept");
        check("dispData_48", 16'(dispData), 16'h0048);
        drdyCur = 1;
        peek(16'hFE04, 16'h0001, "dsr_xfer");
        check("dispValid_done", 16'(dispValid), 16'h0000);
        drdyCur = 0;
        wr(16'hFE04, 16'h0001);
        peek(16'hFE04, 16'h8000, "dsr_clr");

        // Reset with a pending display character and two queued keys
        push(8'h61); push(8'h62);
        wr(16'hFE06, 16'h0055);
        wr(16'hFE06, 16'h0056);
        doReset();
        peek(16'hFE00, 16'h0000, "rst2_kbsr");
        peek(16'hFE04, 16'h8000, "rst2_dsr");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: ra = 16'hFE00;
                1: ra = 16'hFE02;
                2: ra = 16'hFE04;
                3: ra = 16'hFE06;
                default: ra = 16'($urandom);
            endcase
            drive(($urandom_range(0, 99) < 2), ra, 16'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3),
                  8'($urandom), 1'($urandom), 1'($urandom), 0, 16'h0000, "");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
